// File: rtl/rv32_instr_encoder.sv
// RV32 instruction encoder: packs discrete instruction fields into a 32-bit
// word, range-checks the immediate for its format, and buffers the result in
// a small valid/ready FIFO. Pop statistics are kept in saturating counters.
module rv32_instr_encoder #(
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16,
  parameter bit NOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] enc_word;
  logic [31:0] push_word;
  logic [1:0]  enc_code;
  logic        enc_err;
  logic        sext12, sext13, sext21;

  logic [31:0]   mem_instr [DEPTH];
  logic          mem_err   [DEPTH];
  logic [1:0]    mem_code  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  // Immediate fits when all bits above the field's sign bit equal that sign bit.
  assign sext12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sext13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sext21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // Field packing per instruction format; unused fields are ignored.
  always_comb begin
    enc_word = {25'b0, in_opcode};
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: enc_word = {25'b0, in_opcode};
    endcase
  end

  // Error classification, highest code wins.
  always_comb begin
    enc_code = 2'd0;
    if ((in_fmt > FMT_J) || (in_opcode[1:0] != 2'b11)) begin
      enc_code = 2'd3;
    end else if ((((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]) ||
                 ((in_fmt == FMT_U) && (in_imm[11:0] != 12'd0))) begin
      enc_code = 2'd2;
    end else if ((((in_fmt == FMT_I) || (in_fmt == FMT_S)) && !sext12) ||
                 ((in_fmt == FMT_B) && !sext13) ||
                 ((in_fmt == FMT_J) && !sext21)) begin
      enc_code = 2'd1;
    end
  end

  assign enc_err   = (enc_code != 2'd0);
  assign push_word = (enc_err && NOP_ON_ERR) ? NOP_WORD : enc_word;

  assign in_ready  = (count < (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // FIFO occupancy and pointers; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: word, error flag and code are written as one entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= push_word;
      mem_err[wr_ptr]   <= enc_err;
      mem_code[wr_ptr]  <= enc_code;
    end
  end

  assign out_instr    = out_valid ? mem_instr[rd_ptr] : 32'd0;
  assign out_err      = out_valid ? mem_err[rd_ptr]   : 1'b0;
  assign out_err_code = out_valid ? mem_code[rd_ptr]  : 2'd0;

  // Saturating pop statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (cnt_clr) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (pop) begin
      if (enc_count != '1)            enc_count <= enc_count + CNT_W'(1);
      if (out_err && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: directed test-plan cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_rv32_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [1:0]    out_err_code;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] enc_count, err_count;

  int checks = 0;
  int errors = 0;

  rv32_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CW), .NOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_err_code(out_err_code),
    .cnt_clr(cnt_clr), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } ent_t;

  ent_t    q[$];
  int      m_enc = 0;
  int      m_err = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding computed from signed ranges and shifted fields.
  function automatic ent_t ref_enc(input logic [2:0] f, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
    ent_t        e;
    longint      si;
    logic [31:0] w;
    int          code;
    si = longint'($signed(imm));
    w  = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (f)
      3'd0: w = w | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: w = w | ((imm & 32'hFFF) << 20);
      3'd2: w = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      3'd3: w = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd4: w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      3'd5: w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 20) & 32'h1) << 31);
      default: w = 32'(op);
    endcase
    if (f > 3'd5 || op[1:0] != 2'b11) code = 3;
    else if (((f == 3'd3 || f == 3'd5) && imm[0]) || (f == 3'd4 && (imm & 32'hFFF) != 0)) code = 2;
    else if ((f == 3'd1 || f == 3'd2) && (si < -2048 || si > 2047)) code = 1;
    else if (f == 3'd3 && (si < -4096 || si > 4095)) code = 1;
    else if (f == 3'd5 && (si < -1048576 || si > 1048575)) code = 1;
    else code = 0;
    e.code  = 2'(code);
    e.err   = (code != 0);
    e.instr = e.err ? 32'h0000_0013 : w;
    return e;
  endfunction

  // Model state advances on each clock edge from the pre-edge inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
    end else begin
      bit   do_pop, do_push, head_err;
      ent_t e;
      do_pop   = (q.size() > 0) && out_ready;
      do_push  = in_valid && (q.size() < DEPTH);
      head_err = (q.size() > 0) ? q[0].err : 1'b0;
      if (cnt_clr) begin
        m_enc = 0;
        m_err = 0;
      end else if (do_pop) begin
        if (m_enc < CMAX) m_enc++;
        if (head_err && m_err < CMAX) m_err++;
      end
      e = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (q.size() > 0) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_instr", out_instr, q[0].instr);
        chk("out_err", 32'(out_err), 32'(q[0].err));
        chk("out_err_code", 32'(out_err_code), 32'(q[0].code));
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
        chk("out_instr_idle", out_instr, 32'd0);
        chk("out_err_idle", 32'(out_err), 32'd0);
        chk("out_code_idle", 32'(out_err_code), 32'd0);
      end
      chk("enc_count", 32'(enc_count), 32'(m_enc));
      chk("err_count", 32'(err_count), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Single request into an empty FIFO; word must appear one cycle later.
  task automatic dir(input string name, input logic [2:0] f, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [31:0] imm,
                     input logic [31:0] exp_instr, input logic [1:0] exp_code);
    out_ready = 1'b1;
    set_req(f, op, rd, rs1, rs2, f3, 7'd0, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_instr"}, out_instr, exp_instr);
    chk({name, "_code"}, 32'(out_err_code), 32'(exp_code));
    tick();
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 5))
      0: imm = 32'($signed($urandom_range(0, 40)) - 20);
      1: imm = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)};
      2: case ($urandom_range(0, 7))
           0: imm = 32'd2047;       1: imm = 32'd2048;
           2: imm = 32'hFFFF_F800;  3: imm = 32'hFFFF_F7FF;
           4: imm = 32'd4094;       5: imm = 32'd4096;
           6: imm = 32'h000F_FFFE;  default: imm = 32'h0010_0000;
         endcase
      3: imm = $urandom;
      4: imm = $urandom & 32'hFFFF_F000;
      default: imm = {{11{$urandom_range(0, 1) == 1}}, 21'($urandom)} & ~32'h1;
    endcase
    set_req(3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? 7'($urandom) : {5'($urandom), 2'b11},
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    #20;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Directed encodings from the test plan.
    dir("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    dir("sw",   3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'd8,         32'h0051_2423, 2'd0);
    dir("beq4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0);
    dir("beq2", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFE, 32'hFE00_0FE3, 2'd0);
    dir("jal",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800,       32'h0010_00EF, 2'd0);
    dir("jalo", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h801,       32'h0000_0013, 2'd2);
    dir("irng", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      32'h0000_0013, 2'd1);
    dir("fmt7", 3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      32'h0000_0013, 2'd3);
    dir("opc",  3'd1, 7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0,         32'h0000_0013, 2'd3);

    // Backpressure with three back-to-back requests.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    tick();
    set_req(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    tick();
    set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    tick();
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_instr, 32'hFFF0_0093);
    tick();
    @(negedge clk);
    chk("bp_head_stable", out_instr, 32'hFFF0_0093);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_second", out_instr, 32'h0051_2423);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_third", out_instr, 32'h0010_00EF);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_count1", 32'(in_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_enc_count", 32'(enc_count), 32'd3);
    tick();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick();

    // Clear coincident with a pop.
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_pop_enc", 32'(enc_count), 32'd0);
    chk("clr_pop_err", 32'(err_count), 32'd0);
    tick();

    // Drive enc_count to saturation.
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < CMAX + 6; i++) tick();
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("sat_enc", 32'(enc_count), 32'(CMAX));
    chk("sat_err", 32'(err_count), 32'd0);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      rand_req();
      tick();
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
